seg7_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for an N-digit common-anode 7-segment display.

---
 rtl/seg7_scan_ctrl_if.sv | 25 ++
 rtl/seg7_scan_ctrl.sv | 173 +++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_ctrl_if.sv
// Display-value handshake between a producer and the 7-segment scan controller.
// The producer offers a full N_DIG-digit value; the controller takes it when ready.
interface seg7_scan_ctrl_if #(
  parameter int N_DIG = 4
) ();

  logic [4*N_DIG-1:0] val_in;     // nibble i -> digit i, digit 0 rightmost
  logic               val_valid;  // val_in holds a value to be taken
  logic               val_ready;  // controller can take val_in this cycle

  // Producer side: offers values
  modport master (
    output val_in,
    output val_valid,
    input  val_ready
  );

  // Controller side: accepts values
  modport slave (
    input  val_in,
    input  val_valid,
    output val_ready
  );

endinterface : seg7_scan_ctrl_if

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
// One shared registered decoder (DEC_LAT cycles, nibble in -> segments out) is
// time-shared across all digits: dig_nib feeds the decoder, an_out selects the
// digit. Each digit slot opens with all anodes off until the decoder output for
// the new digit has settled plus BLANK_CYC of dead time against ghosting.
// New values are double-buffered (pend -> active) and only swapped at a frame
// boundary, so a frame never shows a mix of two values.
module seg7_scan_ctrl #(
  parameter int N_DIG       = 4,       // number of digits (>= 2)
  parameter int REFRESH_DIV = 100000,  // clk cycles per digit slot
  parameter int DEC_LAT     = 2,       // decoder latency, nibble -> segments
  parameter int BLANK_CYC   = 16       // anode dead time at the start of a slot
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  seg7_scan_ctrl_if.slave  val_if,
  input  logic             blank_lz,
  output logic [3:0]       dig_nib,
  output logic [N_DIG-1:0] an_out,
  output logic             frame_done
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(N_DIG);

  // Last prescaler count of a slot.
  localparam logic [PW-1:0] PRE_TC   = PW'(REFRESH_DIV - 1);
  // First prescaler count at which the decoder output belongs to the
  // current digit and the dead time has elapsed.
  localparam logic [PW-1:0] PRE_ON   = PW'(DEC_LAT + BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIG - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t             state;
  logic [PW-1:0]      pre_cnt;
  logic [IW-1:0]      idx;

  logic [4*N_DIG-1:0] active;       // value being displayed
  logic [4*N_DIG-1:0] pend;         // value waiting for the next frame boundary
  logic               pend_full;
  logic               val_ready_q;

  logic [PW-1:0]      pre_inc;
  logic [IW-1:0]      idx_inc;
  logic [N_DIG-1:0]   dig_en;
  logic [3:0]         nib_sel;
  logic               boundary;
  logic               xfer;
  logic               pend_full_nxt;
  logic               nz_above;

  assign val_if.val_ready = val_ready_q;

  // Incremented counters shared by the FSM branches.
  always_comb begin
    pre_inc = pre_cnt + 1'b1;
    idx_inc = idx + 1'b1;
  end

  // Per-digit enable: with blank_lz, digit i>=1 is dark when it and every
  // digit to its left are zero. Digit 0 always lights so zero shows as "0".
  always_comb begin
    // NOTE: every variable written here gets a value before any condition,
    // otherwise paths that skip the assignment would infer a latch.
    dig_en   = '0;
    nz_above = 1'b0;
    for (int i = N_DIG - 1; i >= 0; i--) begin
      nz_above  = nz_above | (|active[4*i +: 4]);
      dig_en[i] = (i == 0) || !blank_lz || nz_above;
    end
  end

  // Nibble of the digit currently selected by idx.
  always_comb begin
    nib_sel = active[4*int'(idx) +: 4];
  end

  // Swap point for the double buffer and handshake bookkeeping.
  always_comb begin
    boundary      = frame_done || (state == IDLE);
    xfer          = val_if.val_valid && val_ready_q;
    pend_full_nxt = pend_full;
    if (boundary && pend_full) begin
      pend_full_nxt = 1'b0;
    end
    if (xfer) begin
      pend_full_nxt = 1'b1;
    end
  end

  // Scan FSM, prescaler, digit index and the registered display outputs.
  // an_out and frame_done are registered from the values the counters take
  // at the same edge, so they line up with pre_cnt/idx without a cycle of lag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: clocked state is always written with <= so every register
      // samples the pre-edge values, independent of statement order.
      state      <= IDLE;
      pre_cnt    <= '0;
      idx        <= '0;
      dig_nib    <= 4'h0;
      an_out     <= '1;
      frame_done <= 1'b0;
    end else begin
      an_out     <= '1;
      frame_done <= 1'b0;
      dig_nib    <= nib_sel;
      if (!en) begin
        state   <= IDLE;
        pre_cnt <= '0;
        idx     <= '0;
      end else begin
        case (state)
          IDLE: begin
            state   <= SCAN;
            pre_cnt <= '0;
            idx     <= '0;
          end
          SCAN: begin
            if (pre_cnt == PRE_TC) begin
              pre_cnt <= '0;
              idx     <= (idx == IDX_LAST) ? '0 : idx_inc;
            end else begin
              pre_cnt <= pre_inc;
              if (pre_inc >= PRE_ON && dig_en[idx]) begin
                an_out <= ~(N_DIG'(1) << idx);
              end
              if (pre_inc == PRE_TC && idx == IDX_LAST) begin
                frame_done <= 1'b1;
              end
            end
          end
          default: begin
            state   <= IDLE;
            pre_cnt <= '0;
            idx     <= '0;
          end
        endcase
      end
    end
  end

  // Double-buffer control: active only changes at a frame boundary, and
  // val_ready reflects whether the pending slot will be free next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active      <= '0;
      pend_full   <= 1'b0;
      val_ready_q <= 1'b1;
    end else begin
      if (boundary && pend_full) begin
        active <= pend;
      end
      pend_full   <= pend_full_nxt;
      val_ready_q <= ~pend_full_nxt;
    end
  end

  // Pending value storage.
  // NOTE: the pend data needs no reset; pend_full guards every read of it,
  // and clearing the flag on reset is what discards a held value.
  always_ff @(posedge clk) begin
    if (xfer) begin
      pend <= val_if.val_in;
    end
  end

endmodule : seg7_scan_ctrl

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (N_DIG=4, REFRESH_DIV=8, DEC_LAT=2,
// BLANK_CYC=1). A behavioural model tracks time since scanning started and
// derives slot, position and anode pattern from it; directed scenarios pin
// hand-computed values, then randomized traffic exercises the handshake.
module tb_seg7_scan_ctrl;

  localparam int N     = 4;
  localparam int DIV   = 8;
  localparam int LAT   = 2;
  localparam int BLK   = 1;
  localparam int FRAME = N * DIV;
  localparam int THR   = LAT + BLK;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b1;
  logic         blank_lz = 1'b0;
  logic [3:0]   dig_nib;
  logic [N-1:0] an_out;
  logic         frame_done;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_on   = 1'b0;

  seg7_scan_ctrl_if #(.N_DIG(N)) vif ();

  seg7_scan_ctrl #(
    .N_DIG      (N),
    .REFRESH_DIV(DIV),
    .DEC_LAT    (LAT),
    .BLANK_CYC  (BLK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .val_if    (vif),
    .blank_lz  (blank_lz),
    .dig_nib   (dig_nib),
    .an_out    (an_out),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic             scan;    // scanning (not idle)
    logic [31:0]      t;       // cycles since scanning started
    logic [4*N-1:0]   active;
    logic [4*N-1:0]   pend;
    logic             full;
    logic             lz;      // blank_lz as seen at the last edge
    logic [3:0]       nib;
  } model_t;

  model_t m;

  function automatic int cur_idx(model_t s);
    return s.scan ? int'((s.t / DIV) % N) : 0;
  endfunction

  function automatic logic is_fd(model_t s);
    return s.scan && ((s.t % FRAME) == FRAME - 1);
  endfunction

  function automatic logic [N-1:0] exp_an(model_t s);
    logic [N-1:0] r;
    int i;
    r = '1;
    i = cur_idx(s);
    if (s.scan && (s.t % DIV) >= THR) begin
      if (i == 0 || !s.lz || ((s.active >> (4 * i)) != 0)) r[i] = 1'b0;
    end
    return r;
  endfunction

  function automatic model_t next_model(model_t s, logic en_i, logic lz_i,
                                        logic valid_i, logic [4*N-1:0] val_i);
    model_t n;
    logic   bnd;
    logic   hs;
    n     = s;
    bnd   = !s.scan || is_fd(s);
    hs    = valid_i && !s.full;
    n.nib = s.active[4*cur_idx(s) +: 4];
    n.lz  = lz_i;
    if (bnd && s.full) begin
      n.active = s.pend;
      n.full   = 1'b0;
    end
    if (hs) begin
      n.pend = val_i;
      n.full = 1'b1;
    end
    if (!en_i) begin
      n.scan = 1'b0;
      n.t    = '0;
    end else if (!s.scan) begin
      n.scan = 1'b1;
      n.t    = '0;
    end else begin
      n.t = s.t + 1;
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '0;
    else     m <= next_model(m, en, blank_lz, vif.val_valid, vif.val_in);
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (mon_on && !rst) begin
      check("dig_nib", dig_nib, m.nib);
      check("an_out", an_out, exp_an(m));
      check("frame_done", frame_done, is_fd(m));
      check("val_ready", vif.val_ready, !m.full);
      check("an_at_most_one_low", ($countones(~an_out) <= 1), 1);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fd();
    for (int k = 0; k < 3 * FRAME; k++) begin
      @(negedge clk);
      if (frame_done) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_frame_done: no frame_done within %0d cycles", 3 * FRAME);
  endtask

  logic [3:0] t3_an  [4] = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
  logic [3:0] t3_dig [4] = '{4'h0, 4'h5, 4'h0, 4'h0};

  initial begin
    int seen9;
    int last;
    logic [15:0] msk;
    vif.val_valid = 1'b0;
    vif.val_in    = '0;

    // Reset values
    step(2);
    check("rst_an_out", an_out, 4'hF);
    check("rst_val_ready", vif.val_ready, 1);
    check("rst_dig_nib", dig_nib, 0);
    check("rst_frame_done", frame_done, 0);
    rst    = 1'b0;
    mon_on = 1'b1;

    // 1: load 1234 early; frame 0 shows 0, next frame shows 4,3,2,1
    step(2);
    vif.val_valid = 1'b1;
    vif.val_in    = 16'h1234;
    step(1);
    vif.val_valid = 1'b0;
    check("t1_ready_after_load", vif.val_ready, 0);
    wait_fd();
    step(1);
    check("t1_slot0_p0_dark", an_out, 4'hF);
    step(3);
    check("t1_slot0_p3_an", an_out, 4'b1110);
    check("t1_slot0_p3_nib", dig_nib, 4'h4);
    step(9);
    check("t1_slot1_p4_an", an_out, 4'b1101);
    check("t1_slot1_p4_nib", dig_nib, 4'h3);

    // 2: AAAA accepted, BBBB held until the frame boundary frees pend
    vif.val_valid = 1'b1;
    vif.val_in    = 16'hAAAA;
    step(1);
    vif.val_in = 16'hBBBB;
    check("t2_ready_low", vif.val_ready, 0);
    wait_fd();
    check("t2_ready_low_at_fd", vif.val_ready, 0);
    step(1);
    check("t2_ready_after_fd", vif.val_ready, 1);
    step(1);
    check("t2_bbbb_taken", vif.val_ready, 0);
    vif.val_valid = 1'b0;
    step(3);
    check("t2_shows_a", dig_nib, 4'hA);
    check("t2_an_a", an_out, 4'b1110);
    wait_fd();
    step(5);
    check("t2_shows_b", dig_nib, 4'hB);

    // 3: leading-zero suppression on 0050
    blank_lz      = 1'b1;
    vif.val_valid = 1'b1;
    vif.val_in    = 16'h0050;
    step(1);
    vif.val_valid = 1'b0;
    wait_fd();
    step(1);
    for (int s = 0; s < N; s++) begin
      step(4);
      check($sformatf("t3_slot%0d_an", s), an_out, t3_an[s]);
      check($sformatf("t3_slot%0d_nib", s), dig_nib, t3_dig[s]);
      step(4);
    end

    // 4: en drop at slot 2 / pre_cnt 5, then restart
    step(21);
    en = 1'b0;
    step(1);
    check("t4_dark_after_en0", an_out, 4'hF);
    step(3);
    check("t4_idle_dark", an_out, 4'hF);
    check("t4_idle_no_fd", frame_done, 0);
    en = 1'b1;
    step(3);
    check("t4_p2_dark", an_out, 4'hF);
    step(1);
    check("t4_p3_digit0", an_out, 4'b1110);

    // 5: asynchronous reset with a pending value
    vif.val_valid = 1'b1;
    vif.val_in    = 16'h9999;
    step(1);
    vif.val_valid = 1'b0;
    check("t5_pend_full", vif.val_ready, 0);
    step(8);
    #2 rst = 1'b1;
    #1;
    check("t5_async_an", an_out, 4'hF);
    check("t5_async_ready", vif.val_ready, 1);
    check("t5_async_nib", dig_nib, 0);
    check("t5_async_fd", frame_done, 0);
    step(2);
    rst   = 1'b0;
    seen9 = 0;
    for (int c = 0; c < 80; c++) begin
      step(1);
      if (dig_nib == 4'h9) seen9++;
    end
    check("t5_pend_never_shown", seen9, 0);

    // 6: free run, frame_done period
    blank_lz = 1'b0;
    last     = -1;
    for (int c = 0; c < 200; c++) begin
      step(1);
      if (frame_done) begin
        if (last >= 0) check("t6_period", c - last, FRAME);
        last = c;
      end
    end

    // Randomized traffic: valid, values with zero-heavy upper digits,
    // occasional en drops and blank_lz toggles.
    for (int c = 0; c < 1500; c++) begin
      case ($urandom_range(0, 3))
        0:       msk = 16'hFFFF;
        1:       msk = 16'h00FF;
        2:       msk = 16'h000F;
        default: msk = 16'h0F0F;
      endcase
      vif.val_valid = ($urandom_range(0, 2) == 0);
      vif.val_in    = 16'($urandom) & msk;
      en            = ($urandom_range(0, 99) >= 2);
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      step(1);
    end
    vif.val_valid = 1'b0;
    en            = 1'b1;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_seg7_scan_ctrl
